// File: rtl/m_data_memory_if.sv
// Memory-stage data bus between the M-stage datapath and the data memory.
interface m_data_memory_if;
  logic [31:0] PC_M;
  logic [31:0] Addr_M;
  logic [31:0] WData_M;
  logic        MemWrite_M;
  logic        MemRead_M;
  logic [2:0]  MemOp_M;
  logic [31:0] ReadData_M;
  logic        Exc_M;

  modport master (
    output PC_M, Addr_M, WData_M, MemWrite_M, MemRead_M, MemOp_M,
    input  ReadData_M, Exc_M
  );

  modport slave (
    input  PC_M, Addr_M, WData_M, MemWrite_M, MemRead_M, MemOp_M,
    output ReadData_M, Exc_M
  );
endinterface

// File: rtl/m_data_memory.sv
// M-stage data memory: word/half/byte loads (zero latency, sign/zero
// extended) and lane-merged stores committed on the rising clock edge.
// Asynchronous active-low reset clears the whole array.
module m_data_memory #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned ADDR_W      = 12
) (
  input logic            clk,
  input logic            reset,
  m_data_memory_if.slave bus
);

  typedef enum logic [2:0] {
    OP_W  = 3'b000,
    OP_HS = 3'b001,
    OP_HU = 3'b010,
    OP_BS = 3'b011,
    OP_BU = 3'b100
  } mem_op_e;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       cur_word;
  logic [31:0]       store_word_d;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              is_word, is_half, is_byte, is_illegal;
  logic              access, fault, store_en;
  mem_op_e           op;

  assign op       = mem_op_e'(bus.MemOp_M);
  assign idx      = bus.Addr_M[ADDR_W+1:2];
  assign lane     = bus.Addr_M[1:0];
  assign cur_word = mem_q[idx];
  assign access   = bus.MemRead_M | bus.MemWrite_M;
  assign store_en = bus.MemWrite_M & ~fault;

  // Decode access size and detect alignment/range/opcode faults.
  always_comb begin
    is_word    = 1'b0;
    is_half    = 1'b0;
    is_byte    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_W:         is_word = 1'b1;
      OP_HS, OP_HU: is_half = 1'b1;
      OP_BS, OP_BU: is_byte = 1'b1;
      default:      is_illegal = 1'b1;
    endcase
    fault = access & ( is_illegal
                     | (is_word && lane != 2'b00)
                     | (is_half && lane[0])
                     | (bus.Addr_M >= 32'(4 * DEPTH_WORDS)) );
  end

  // Extract the addressed lane/half and extend it for the load result.
  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0: byte_sel = cur_word[7:0];
      2'd1: byte_sel = cur_word[15:8];
      2'd2: byte_sel = cur_word[23:16];
      2'd3: byte_sel = cur_word[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
    bus.ReadData_M = '0;
    if (bus.MemRead_M && !fault) begin
      case (op)
        OP_W:    bus.ReadData_M = cur_word;
        OP_HS:   bus.ReadData_M = {{16{half_sel[15]}}, half_sel};
        OP_HU:   bus.ReadData_M = {16'h0000, half_sel};
        OP_BS:   bus.ReadData_M = {{24{byte_sel[7]}}, byte_sel};
        OP_BU:   bus.ReadData_M = {24'h000000, byte_sel};
        default: bus.ReadData_M = '0;
      endcase
    end
  end

  assign bus.Exc_M = fault;

  // Merge store data into the current word so untouched lanes are preserved.
  always_comb begin
    store_word_d = cur_word;
    if (is_word) begin
      store_word_d = bus.WData_M;
    end else if (is_half) begin
      if (lane[1]) store_word_d[31:16] = bus.WData_M[15:0];
      else         store_word_d[15:0]  = bus.WData_M[15:0];
    end else if (is_byte) begin
      case (lane)
        2'd0: store_word_d[7:0]   = bus.WData_M[7:0];
        2'd1: store_word_d[15:8]  = bus.WData_M[7:0];
        2'd2: store_word_d[23:16] = bus.WData_M[7:0];
        2'd3: store_word_d[31:24] = bus.WData_M[7:0];
        default: store_word_d = cur_word;
      endcase
    end
  end

  // Storage array: cleared asynchronously by reset, written on committed stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else if (store_en) begin
      mem_q[idx] <= store_word_d;
    end
  end

  // Write log for comparison against the reference simulator.
  always_ff @(posedge clk) begin
    if (reset && store_en) begin
      $display("@%h: *%h <= %h", bus.PC_M, {bus.Addr_M[31:2], 2'b00}, store_word_d);
    end
  end

endmodule
